// File: rtl/mxv_cmd_parser.sv
// mxv_cmd_parser: receive-side command frame parser for the MxV engine.
// Frame format: 0xFE, LEN, CMD, payload (LEN-1 bytes), 0xEF.
// Commands: 0x01 SET_LEN, 0x03 START_OP, 0x04 LOAD.
// Optional inter-byte timeout enabled by defining MXV_PARSER_TIMEOUT_EN.
module mxv_cmd_parser #(
  parameter int MAX_N = 8
`ifdef MXV_PARSER_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 100000
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  input  logic       busy,
  output logic [7:0] matrix_length,
  output logic [7:0] load_data,
  output logic       load_valid,
  output logic       start_load,
  output logic       end_load,
  output logic       op_start,
  output logic       frame_err,
  output logic       cmd_ok
);

  localparam logic [7:0] SOF         = 8'hFE;
  localparam logic [7:0] EOF         = 8'hEF;
  localparam logic [7:0] CMD_SET_LEN = 8'h01;
  localparam logic [7:0] CMD_START   = 8'h03;
  localparam logic [7:0] CMD_LOAD    = 8'h04;
  localparam logic [7:0] MAX_N_B     = 8'(MAX_N);

  typedef enum logic [2:0] {IDLE, GET_LEN, GET_CMD, GET_PAY, WAIT_EF} state_t;

  state_t     state_q, state_d;
  logic [7:0] len_q, len_d;
  logic [7:0] cmd_q, cmd_d;
  logic [7:0] rem_q, rem_d;
  logic [7:0] cand_q, cand_d;
  logic       rej_q, rej_d;
  logic [7:0] ml_q, ml_d;
  logic [7:0] ld_q, ld_d;
  logic       lv_q, lv_d;
  logic       sl_q, sl_d;
  logic       el_q, el_d;
  logic       os_q, os_d;
  logic       err_q, err_d;
  logic       ok_q, ok_d;

`ifdef MXV_PARSER_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);
  logic [TW-1:0] to_q, to_d;
`endif

  // State, frame context and registered strobes
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      len_q   <= '0;
      cmd_q   <= '0;
      rem_q   <= '0;
      cand_q  <= '0;
      rej_q   <= 1'b0;
      ml_q    <= 8'd4;
      ld_q    <= '0;
      lv_q    <= 1'b0;
      sl_q    <= 1'b0;
      el_q    <= 1'b0;
      os_q    <= 1'b0;
      err_q   <= 1'b0;
      ok_q    <= 1'b0;
`ifdef MXV_PARSER_TIMEOUT_EN
      to_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cmd_q   <= cmd_d;
      rem_q   <= rem_d;
      cand_q  <= cand_d;
      rej_q   <= rej_d;
      ml_q    <= ml_d;
      ld_q    <= ld_d;
      lv_q    <= lv_d;
      sl_q    <= sl_d;
      el_q    <= el_d;
      os_q    <= os_d;
      err_q   <= err_d;
      ok_q    <= ok_d;
`ifdef MXV_PARSER_TIMEOUT_EN
      to_q    <= to_d;
`endif
    end
  end

  // Next-state, frame bookkeeping and strobe generation per received byte
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cmd_d   = cmd_q;
    rem_d   = rem_q;
    cand_d  = cand_q;
    rej_d   = rej_q;
    ml_d    = ml_q;
    ld_d    = ld_q;
    lv_d    = 1'b0;
    sl_d    = 1'b0;
    el_d    = 1'b0;
    os_d    = 1'b0;
    err_d   = 1'b0;
    ok_d    = 1'b0;
`ifdef MXV_PARSER_TIMEOUT_EN
    to_d    = '0;
`endif

    if (rx_valid) begin
      unique case (state_q)
        IDLE: begin
          // Anything other than SOF is dropped; this is the resync path.
          if (rx_data == SOF) state_d = GET_LEN;
        end
        GET_LEN: begin
          len_d = rx_data;
          if (rx_data == 8'd0) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = GET_CMD;
          end
        end
        GET_CMD: begin
          cmd_d  = rx_data;
          rem_d  = len_q - 8'd1;
          rej_d  = busy;
          cand_d = '0;
          if (rx_data == CMD_LOAD && !busy) sl_d = 1'b1;
          state_d = (len_q == 8'd1) ? WAIT_EF : GET_PAY;
        end
        GET_PAY: begin
          // Payload bytes are data even when they look like delimiters.
          rem_d = rem_q - 8'd1;
          if (cmd_q == CMD_LOAD && !rej_q) begin
            ld_d = rx_data;
            lv_d = 1'b1;
          end
          // Only the first payload byte is the length candidate.
          if (cmd_q == CMD_SET_LEN && rem_q == len_q - 8'd1) cand_d = rx_data;
          if (rem_q == 8'd1) state_d = WAIT_EF;
        end
        WAIT_EF: begin
          state_d = IDLE;
          if (rx_data != EOF || rej_q) begin
            err_d = 1'b1;
          end else begin
            unique case (cmd_q)
              CMD_SET_LEN: begin
                if (len_q == 8'd2 && cand_q >= 8'd1 && cand_q <= MAX_N_B) begin
                  ml_d = cand_q;
                  ok_d = 1'b1;
                end else begin
                  err_d = 1'b1;
                end
              end
              CMD_START: begin
                if (len_q == 8'd1) begin
                  os_d = 1'b1;
                  ok_d = 1'b1;
                end else begin
                  err_d = 1'b1;
                end
              end
              CMD_LOAD: begin
                el_d = 1'b1;
                ok_d = 1'b1;
              end
              default: err_d = 1'b1;
            endcase
          end
        end
        default: state_d = IDLE;
      endcase
    end
`ifdef MXV_PARSER_TIMEOUT_EN
    else if (state_q != IDLE) begin
      // Stalled mid-frame: abandon after TIMEOUT_CYC quiet cycles.
      if (to_q == TO_LAST) begin
        err_d   = 1'b1;
        state_d = IDLE;
      end else begin
        to_d = to_q + 1'b1;
      end
    end
`endif
  end

  assign matrix_length = ml_q;
  assign load_data     = ld_q;
  assign load_valid    = lv_q;
  assign start_load    = sl_q;
  assign end_load      = el_q;
  assign op_start      = os_q;
  assign frame_err     = err_q;
  assign cmd_ok        = ok_q;

endmodule

// File: tb/tb_mxv_cmd_parser.sv
// tb_mxv_cmd_parser: table-driven byte vectors plus reset / timeout sequences.
module tb_mxv_cmd_parser;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       busy;
  logic [7:0] matrix_length;
  logic [7:0] load_data;
  logic       load_valid, start_load, end_load, op_start, frame_err, cmd_ok;

  int n_chk  = 0;
  int n_pass = 0;

  // strobe vector: {load_valid, start_load, end_load, op_start, frame_err, cmd_ok}
  localparam logic [5:0] NO = 6'b000000;
  localparam logic [5:0] LV = 6'b100000;
  localparam logic [5:0] SL = 6'b010000;
  localparam logic [5:0] EL = 6'b001000;
  localparam logic [5:0] OS = 6'b000100;
  localparam logic [5:0] ER = 6'b000010;
  localparam logic [5:0] OK = 6'b000001;

  typedef struct {
    logic [7:0] d;
    logic       b;
    logic [5:0] s;
    logic [7:0] ld;
    logic [7:0] ml;
  } vec_t;

  vec_t vecs[$];

  mxv_cmd_parser #(
    .MAX_N(8)
`ifdef MXV_PARSER_TIMEOUT_EN
    , .TIMEOUT_CYC(20)
`endif
  ) dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data), .busy(busy),
    .matrix_length(matrix_length), .load_data(load_data), .load_valid(load_valid),
    .start_load(start_load), .end_load(end_load), .op_start(op_start),
    .frame_err(frame_err), .cmd_ok(cmd_ok)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] strobes();
    return {load_valid, start_load, end_load, op_start, frame_err, cmd_ok};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  // Present one byte for one cycle; returns at the negedge after it was taken.
  task automatic send(input logic [7:0] d, input logic b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = d;
    busy     = b;
    @(negedge clk);
    rx_valid = 1'b0;
    busy     = 1'b0;
  endtask

  task automatic add(input logic [7:0] d, input logic b, input logic [5:0] s,
                     input logic [7:0] ld, input logic [7:0] ml);
    vec_t v;
    v.d = d; v.b = b; v.s = s; v.ld = ld; v.ml = ml;
    vecs.push_back(v);
  endtask

  initial begin
    reset = 1'b1; rx_valid = 1'b0; rx_data = '0; busy = 1'b0;

    // SET_LEN 3
    add(8'hFE,0,NO,0,4); add(8'h02,0,NO,0,4); add(8'h01,0,NO,0,4); add(8'h03,0,NO,0,4);
    add(8'hEF,0,OK,0,3);
    // LOAD with delimiter-valued payload
    add(8'hFE,0,NO,0,3); add(8'h05,0,NO,0,3); add(8'h04,0,SL,0,3);
    add(8'h11,0,LV,8'h11,3); add(8'hFE,0,LV,8'hFE,3); add(8'hEF,0,LV,8'hEF,3);
    add(8'h22,0,LV,8'h22,3); add(8'hEF,0,EL|OK,0,3);
    // START_OP
    add(8'hFE,0,NO,0,3); add(8'h01,0,NO,0,3); add(8'h03,0,NO,0,3); add(8'hEF,0,OS|OK,0,3);
    // START_OP rejected by busy at CMD
    add(8'hFE,0,NO,0,3); add(8'h01,0,NO,0,3); add(8'h03,1,NO,0,3); add(8'hEF,0,ER,0,3);
    // busy outside the CMD byte is irrelevant
    add(8'hFE,1,NO,0,3); add(8'h01,1,NO,0,3); add(8'h03,0,NO,0,3); add(8'hEF,1,OS|OK,0,3);
    // SET_LEN above MAX_N
    add(8'hFE,0,NO,0,3); add(8'h02,0,NO,0,3); add(8'h01,0,NO,0,3); add(8'h09,0,NO,0,3);
    add(8'hEF,0,ER,0,3);
    // bad terminator
    add(8'hFE,0,NO,0,3); add(8'h01,0,NO,0,3); add(8'h03,0,NO,0,3); add(8'hAA,0,ER,0,3);
    // LEN 0 then a good frame
    add(8'hFE,0,NO,0,3); add(8'h00,0,ER,0,3);
    add(8'hFE,0,NO,0,3); add(8'h01,0,NO,0,3); add(8'h03,0,NO,0,3); add(8'hEF,0,OS|OK,0,3);
    // garbage then SET_LEN MAX_N
    add(8'h55,0,NO,0,3); add(8'hEF,0,NO,0,3); add(8'h00,0,NO,0,3);
    add(8'hFE,0,NO,0,3); add(8'h02,0,NO,0,3); add(8'h01,0,NO,0,3); add(8'h08,0,NO,0,3);
    add(8'hEF,0,OK,0,8);
    // SET_LEN with LEN 3 is rejected even with a legal candidate
    add(8'hFE,0,NO,0,8); add(8'h03,0,NO,0,8); add(8'h01,0,NO,0,8); add(8'h02,0,NO,0,8);
    add(8'h05,0,NO,0,8); add(8'hEF,0,ER,0,8);
    // SET_LEN 0 rejected, SET_LEN 1 accepted
    add(8'hFE,0,NO,0,8); add(8'h02,0,NO,0,8); add(8'h01,0,NO,0,8); add(8'h00,0,NO,0,8);
    add(8'hEF,0,ER,0,8);
    add(8'hFE,0,NO,0,8); add(8'h02,0,NO,0,8); add(8'h01,0,NO,0,8); add(8'h01,0,NO,0,8);
    add(8'hEF,0,OK,0,1);
    // unknown command
    add(8'hFE,0,NO,0,1); add(8'h01,0,NO,0,1); add(8'h07,0,NO,0,1); add(8'hEF,0,ER,0,1);
    // LOAD closed badly: no end_load
    add(8'hFE,0,NO,0,1); add(8'h02,0,NO,0,1); add(8'h04,0,SL,0,1); add(8'h33,0,LV,8'h33,1);
    add(8'h00,0,ER,0,1);

    // reset state
    repeat (2) @(negedge clk);
    chk("reset_strobes", 32'(strobes()), 32'(NO));
    chk("reset_ml", 32'(matrix_length), 32'd4);
    chk("reset_ld", 32'(load_data), 32'd0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      send(vecs[i].d, vecs[i].b);
      chk($sformatf("vec%0d_strobes", i), 32'(strobes()), 32'(vecs[i].s));
      chk($sformatf("vec%0d_ml", i), 32'(matrix_length), 32'(vecs[i].ml));
      if (vecs[i].s[5]) chk($sformatf("vec%0d_ld", i), 32'(load_data), 32'(vecs[i].ld));
    end

    // strobes last one cycle only
    @(negedge clk);
    chk("pulse_width", 32'(strobes()), 32'(NO));

    // reset in the middle of a LOAD frame
    send(8'hFE,0); send(8'h03,0); send(8'h04,0); send(8'h11,0);
    chk("midload_lv", 32'(load_valid), 32'd1);
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    chk("midreset_strobes", 32'(strobes()), 32'(NO));
    chk("midreset_ml", 32'(matrix_length), 32'd4);
    chk("midreset_ld", 32'(load_data), 32'd0);
    reset = 1'b0;
    send(8'h22,0);
    chk("after_reset_22", 32'(strobes()), 32'(NO));
    send(8'hEF,0);
    chk("after_reset_ef", 32'(strobes()), 32'(NO));
    send(8'hFE,0); send(8'h01,0); send(8'h03,0); send(8'hEF,0);
    chk("after_reset_op", 32'(strobes()), 32'(OS|OK));

`ifdef MXV_PARSER_TIMEOUT_EN
    begin
      int n;
      n = 0;
      send(8'hFE,0); send(8'h03,0); send(8'h04,0); send(8'h11,0);
      for (int k = 1; k <= 40; k++) begin
        @(negedge clk);
        chk($sformatf("to_no_el_%0d", k), 32'(end_load), 32'd0);
        if (frame_err) begin n = k; break; end
      end
      chk("timeout_cycles", 32'(n), 32'd20);
      send(8'hFE,0); send(8'h01,0); send(8'h03,0); send(8'hEF,0);
      chk("after_timeout_op", 32'(strobes()), 32'(OS|OK));
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mxv_cmd_parser.md
Name: mxv_cmd_parser

Overview:
- Receive-side counterpart of the MxV result framer.
- Parses command frames arriving byte-by-byte from the UART receiver; frame format: 0xFE, LEN, CMD, payload (LEN-1 bytes), 0xEF.
- Generates the control strobes that drive the MxV control FSM: start_load, end_load, op_start.
- Latches matrix_length and streams matrix/vector load bytes toward the FIFO fill logic.

Parameters:
- MAX_N, 8, largest accepted matrix_length; SET_LEN values 1..MAX_N are legal.
- TIMEOUT_CYC, 100000, inter-byte timeout in clk cycles (optional feature only).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- rx_valid  in  1  one-cycle strobe: rx_data holds a received byte
- rx_data  in  8  received byte
- busy  in  1  high while an operation or result transmission is in progress
- matrix_length  out  8  latched matrix dimension
- load_data  out  8  payload byte of a LOAD frame
- load_valid  out  1  one-cycle strobe qualifying load_data
- start_load  out  1  one-cycle pulse: a LOAD frame has begun
- end_load  out  1  one-cycle pulse: a LOAD frame closed correctly
- op_start  out  1  one-cycle pulse: a START_OP frame closed correctly
- frame_err  out  1  one-cycle pulse: the frame was discarded
- cmd_ok  out  1  one-cycle pulse: any frame was accepted

Behaviour:
- Reset (synchronous, active-high, so it takes effect on the next clk edge):
  - state goes to IDLE.
  - matrix_length = 8'd4.
  - All strobes = 0, load_data = 0.
  - Byte and timeout counters are cleared.
  - A reset in the middle of a frame abandons the frame and pulses nothing.
- All strobes are registered and appear one cycle after the rx_valid edge that caused them.
- Cycles without rx_valid hold the state.
- States and transitions:
  - IDLE: on 0xFE go to GET_LEN. Any other byte is ignored silently; this is how the parser resyncs.
  - GET_LEN: store LEN. If LEN==0, pulse frame_err and go to IDLE. Otherwise go to GET_CMD.
  - GET_CMD: store CMD and set remaining = LEN-1.
    - If busy=1 on this byte, mark the frame rejected. Frame_err is pulsed at close, and no start_load is issued.
    - If CMD==0x04 and the frame is not rejected, pulse start_load.
    - If remaining==0, go to WAIT_EF. Otherwise go to GET_PAY.
  - GET_PAY: each byte decrements remaining.
    - For LOAD: load_data = byte and load_valid pulses.
    - For SET_LEN: the first payload byte is stored as the candidate length; further bytes are ignored.
    - When remaining reaches 0, go to WAIT_EF.
    - Payload bytes equal to 0xFE or 0xEF are data, not delimiters.
  - WAIT_EF: go to IDLE in every case.
    - If the byte is not 0xEF, pulse frame_err. For LOAD, end_load is not pulsed; the downstream side uses frame_err to flush.
    - If the byte is 0xEF, execute CMD:
      - 0x01 SET_LEN: needs LEN==2 and candidate in 1..MAX_N. Then update matrix_length and pulse cmd_ok; otherwise pulse frame_err.
      - 0x03 START_OP: needs LEN==1. Then pulse op_start and cmd_ok.
      - 0x04 LOAD: pulse end_load and cmd_ok.
      - Any other CMD, or a rejected frame: pulse frame_err.
- frame_err and cmd_ok are never high in the same cycle.
- matrix_length changes only on an accepted SET_LEN.
- Counters are 8 bit and LEN 255 is legal, so there is no wrap-around.

Optional Feature:
- Macro: MXV_PARSER_TIMEOUT_EN.
- Defined:
  - A counter runs in every state except IDLE and is cleared on each rx_valid.
  - When it reaches TIMEOUT_CYC-1: pulse frame_err and go to IDLE.
  - A LOAD frame that times out gets no end_load.
- Not defined: no counter exists and the parser waits indefinitely mid-frame.

Test Plan:
- Frame FE 02 01 03 EF -> cmd_ok one cycle after the EF byte; matrix_length = 3; no frame_err.
- Frame FE 05 04 11 FE EF 22 EF -> start_load after the CMD byte; load_valid x4 with load_data 11, FE, EF, 22; end_load + cmd_ok after the final EF.
- Frame FE 01 03 EF with busy=0 -> op_start + cmd_ok. The same frame with busy=1 at the CMD byte -> frame_err only, no op_start.
- Errors:
  - FE 02 01 09 EF with MAX_N=8 -> frame_err; matrix_length unchanged.
  - FE 01 03 AA -> frame_err.
  - FE 00 -> frame_err; the following valid frame is accepted.
- Garbage bytes 55 EF 00 before a valid frame -> ignored. Reset asserted mid-LOAD -> all outputs 0 and matrix_length = 4; no end_load.
- With MXV_PARSER_TIMEOUT_EN and TIMEOUT_CYC=20: FE 03 04 11, then idle for 20 cycles -> frame_err exactly TIMEOUT_CYC cycles after the last byte; parser back in IDLE.
